// File: rtl/commit_trace_buffer.sv
// Commit-trace capture unit: classifies each retiring instruction, tags it with a
// sequence number and queues it in a first-word-fall-through FIFO for a host to drain.
//
// state   | meaning
// --------+------------------------------------------------------------
// RUN     | capturing enabled cycles, counters advancing
// STOPPED | halt seen or watchdog expired; FIFO still drains, rst exits
module commit_trace_buffer #(
    parameter int DEPTH       = 16,
    parameter int DATA_W      = 16,
    parameter int CNT_W       = 32,
    parameter int CYCLE_LIMIT = 100000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       capture_en,
    input  logic [DATA_W-1:0]          pc,
    input  logic [DATA_W-1:0]          inst,
    input  logic                       reg_write,
    input  logic                       mem_read,
    input  logic                       mem_write,
    input  logic                       halt,
    input  logic [3:0]                 wr_reg,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W-1:0]          mem_addr,
    input  logic [DATA_W-1:0]          mem_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [2:0]                 rd_type,
    output logic [CNT_W-1:0]           rd_inum,
    output logic [DATA_W-1:0]          rd_pc,
    output logic [DATA_W-1:0]          rd_value,
    output logic [DATA_W-1:0]          rd_addr,
    output logic [3:0]                 rd_reg,
    output logic [CNT_W-1:0]           cycle_count,
    output logic [CNT_W-1:0]           inst_count,
    output logic [CNT_W-1:0]           drop_count,
    output logic                       halted,
    output logic                       timeout,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(CYCLE_LIMIT - 1);

    localparam logic [2:0] T_REG   = 3'd0;
    localparam logic [2:0] T_LOAD  = 3'd1;
    localparam logic [2:0] T_STORE = 3'd2;
    localparam logic [2:0] T_NOP   = 3'd3;
    localparam logic [2:0] T_HALT  = 3'd4;

    typedef enum logic {RUN, STOPPED} state_t;

    state_t state, state_next;

    logic              capture;
    logic              limit_hit;
    logic              full;
    logic              pop;
    logic              push_ok;
    logic [2:0]        rec_type;
    logic [DATA_W-1:0] rec_value;
    logic [DATA_W-1:0] rec_addr;
    logic [3:0]        rec_reg;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    logic [2:0]        mem_type  [DEPTH];
    logic [CNT_W-1:0]  mem_inum  [DEPTH];
    logic [DATA_W-1:0] mem_pc    [DEPTH];
    logic [DATA_W-1:0] mem_value [DEPTH];
    logic [DATA_W-1:0] mem_addr_q[DEPTH];
    logic [3:0]        mem_reg   [DEPTH];

    // The instruction word is part of the CPU commit bundle but is not recorded.
    logic unused_inst;
    assign unused_inst = ^inst;

    assign limit_hit = (cycle_count == LIMIT_M1);

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            RUN: begin
                capture = capture_en & ~rst;
                if (capture && (halt || limit_hit)) state_next = STOPPED;
            end
            default: state_next = STOPPED;
        endcase
    end

    always_comb begin
        rec_type  = T_NOP;
        rec_value = '0;
        rec_addr  = '0;
        rec_reg   = '0;
        if (halt) begin
            rec_type = T_HALT;
        end else if (reg_write && mem_read) begin
            rec_type  = T_LOAD;
            rec_value = wr_data;
            rec_addr  = mem_addr;
            rec_reg   = wr_reg;
        end else if (reg_write) begin
            rec_type  = T_REG;
            rec_value = wr_data;
            rec_reg   = wr_reg;
        end else if (mem_write) begin
            rec_type  = T_STORE;
            rec_value = mem_data;
            rec_addr  = mem_addr;
        end
    end

    assign full     = (level == LW'(DEPTH));
    assign rd_valid = (level != '0);
    assign pop      = rd_valid & rd_ready;
    // A full FIFO still accepts a record when the head leaves in the same cycle.
    assign push_ok  = capture & (~full | pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_type[wr_ptr]   <= rec_type;
            mem_inum[wr_ptr]   <= inst_count;
            mem_pc[wr_ptr]     <= pc;
            mem_value[wr_ptr]  <= rec_value;
            mem_addr_q[wr_ptr] <= rec_addr;
            mem_reg[wr_ptr]    <= rec_reg;
        end
    end

    // Gate the head so the record fields read zero whenever the FIFO is empty.
    assign rd_type  = rd_valid ? mem_type[rd_ptr]   : '0;
    assign rd_inum  = rd_valid ? mem_inum[rd_ptr]   : '0;
    assign rd_pc    = rd_valid ? mem_pc[rd_ptr]     : '0;
    assign rd_value = rd_valid ? mem_value[rd_ptr]  : '0;
    assign rd_addr  = rd_valid ? mem_addr_q[rd_ptr] : '0;
    assign rd_reg   = rd_valid ? mem_reg[rd_ptr]    : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            cycle_count <= '0;
            inst_count  <= '0;
            drop_count  <= '0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (capture) begin
                if (cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
                if (inst_count != '1)  inst_count  <= inst_count + CNT_W'(1);
                if (halt)      halted  <= 1'b1;
                if (limit_hit) timeout <= 1'b1;
                if (!push_ok) begin
                    if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: one main instance plus a short-watchdog
// instance (CYCLE_LIMIT=5) sharing the commit inputs.
module tb_commit_trace_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        capture_en = 1'b0;
    logic [15:0] pc = '0, inst = '0, wr_data = '0, mem_addr = '0, mem_data = '0;
    logic        reg_write = 1'b0, mem_read = 1'b0, mem_write = 1'b0, halt = 1'b0;
    logic [3:0]  wr_reg = '0;
    logic        rd_ready = 1'b0;

    logic        rd_valid;
    logic [2:0]  rd_type;
    logic [31:0] rd_inum, cycle_count, inst_count, drop_count;
    logic [15:0] rd_pc, rd_value, rd_addr;
    logic [3:0]  rd_reg;
    logic        halted, timeout, overflow;
    logic [4:0]  level;

    logic        rst_t = 1'b1, capture_en_t = 1'b0, rd_ready_t = 1'b0;
    logic        rd_valid_t;
    logic [2:0]  rd_type_t;
    logic [31:0] rd_inum_t, cycle_count_t, inst_count_t, drop_count_t;
    logic [15:0] rd_pc_t, rd_value_t, rd_addr_t;
    logic [3:0]  rd_reg_t;
    logic        halted_t, timeout_t, overflow_t;
    logic [4:0]  level_t;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    commit_trace_buffer #(.DEPTH(16), .DATA_W(16), .CNT_W(32), .CYCLE_LIMIT(100000)) dut (
        .clk(clk), .rst(rst), .capture_en(capture_en), .pc(pc), .inst(inst),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .halt(halt),
        .wr_reg(wr_reg), .wr_data(wr_data), .mem_addr(mem_addr), .mem_data(mem_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_type(rd_type), .rd_inum(rd_inum),
        .rd_pc(rd_pc), .rd_value(rd_value), .rd_addr(rd_addr), .rd_reg(rd_reg),
        .cycle_count(cycle_count), .inst_count(inst_count), .drop_count(drop_count),
        .halted(halted), .timeout(timeout), .overflow(overflow), .level(level)
    );

    commit_trace_buffer #(.DEPTH(16), .DATA_W(16), .CNT_W(32), .CYCLE_LIMIT(5)) dut_t (
        .clk(clk), .rst(rst_t), .capture_en(capture_en_t), .pc(pc), .inst(inst),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .halt(halt),
        .wr_reg(wr_reg), .wr_data(wr_data), .mem_addr(mem_addr), .mem_data(mem_data),
        .rd_valid(rd_valid_t), .rd_ready(rd_ready_t), .rd_type(rd_type_t), .rd_inum(rd_inum_t),
        .rd_pc(rd_pc_t), .rd_value(rd_value_t), .rd_addr(rd_addr_t), .rd_reg(rd_reg_t),
        .cycle_count(cycle_count_t), .inst_count(inst_count_t), .drop_count(drop_count_t),
        .halted(halted_t), .timeout(timeout_t), .overflow(overflow_t), .level(level_t)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        capture_en = 1'b0; reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; halt = 1'b0;
        pc = '0; inst = '0; wr_reg = '0; wr_data = '0; mem_addr = '0; mem_data = '0;
        rd_ready = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", rd_valid); end
        total++; if (level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
        total++; if ({cycle_count, inst_count, drop_count} !== 96'd0) begin bad++; $display("FAIL reset_counters got=%0h/%0h/%0h exp=0", cycle_count, inst_count, drop_count); end
        total++; if ({halted, timeout, overflow} !== 3'b000) begin bad++; $display("FAIL reset_status got=%b exp=000", {halted, timeout, overflow}); end
        total++; if ({rd_type, rd_inum, rd_pc, rd_value, rd_addr, rd_reg} !== '0) begin bad++; $display("FAIL reset_fields got=%0h/%0h/%0h/%0h exp=0", rd_type, rd_inum, rd_value, rd_addr); end
    endtask

    task automatic test_reg_write();
        do_reset();
        capture_en = 1'b1; reg_write = 1'b1; wr_reg = 4'd3; wr_data = 16'h00A5; pc = 16'h0002;
        mem_addr = 16'h0777;
        tick();
        clear_inputs();
        total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL reg_valid got=%0h exp=1", rd_valid); end
        total++; if (rd_type !== 3'd0) begin bad++; $display("FAIL reg_type got=%0d exp=0", rd_type); end
        total++; if (rd_inum !== 32'd0) begin bad++; $display("FAIL reg_inum got=%0d exp=0", rd_inum); end
        total++; if (rd_reg !== 4'd3) begin bad++; $display("FAIL reg_reg got=%0d exp=3", rd_reg); end
        total++; if (rd_value !== 16'h00A5) begin bad++; $display("FAIL reg_value got=%0h exp=a5", rd_value); end
        total++; if (rd_pc !== 16'h0002) begin bad++; $display("FAIL reg_pc got=%0h exp=2", rd_pc); end
        total++; if (rd_addr !== 16'h0000) begin bad++; $display("FAIL reg_addr got=%0h exp=0", rd_addr); end
        total++; if (level !== 5'd1) begin bad++; $display("FAIL reg_level got=%0d exp=1", level); end
        total++; if (inst_count !== 32'd1) begin bad++; $display("FAIL reg_icount got=%0d exp=1", inst_count); end
        total++; if (cycle_count !== 32'd1) begin bad++; $display("FAIL reg_ccount got=%0d exp=1", cycle_count); end
    endtask

    task automatic test_load_store_nop();
        do_reset();
        rd_ready = 1'b1; capture_en = 1'b1;
        reg_write = 1'b1; mem_read = 1'b1; wr_reg = 4'd5; wr_data = 16'h1234; mem_addr = 16'h0010; pc = 16'h0004;
        tick();
        total++; if ({rd_type, rd_inum} !== {3'd1, 32'd0}) begin bad++; $display("FAIL load_type_inum got=%0d/%0d exp=1/0", rd_type, rd_inum); end
        total++; if ({rd_value, rd_addr, rd_reg} !== {16'h1234, 16'h0010, 4'd5}) begin bad++; $display("FAIL load_fields got=%0h/%0h/%0h exp=1234/10/5", rd_value, rd_addr, rd_reg); end
        total++; if (level !== 5'd1) begin bad++; $display("FAIL load_level got=%0d exp=1", level); end
        reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b1; mem_addr = 16'h0020; mem_data = 16'hBEEF; pc = 16'h0006;
        tick();
        total++; if ({rd_type, rd_inum} !== {3'd2, 32'd1}) begin bad++; $display("FAIL store_type_inum got=%0d/%0d exp=2/1", rd_type, rd_inum); end
        total++; if ({rd_value, rd_addr, rd_reg} !== {16'hBEEF, 16'h0020, 4'd0}) begin bad++; $display("FAIL store_fields got=%0h/%0h/%0h exp=beef/20/0", rd_value, rd_addr, rd_reg); end
        total++; if (level !== 5'd1) begin bad++; $display("FAIL store_level got=%0d exp=1", level); end
        mem_write = 1'b0; pc = 16'h0008;
        tick();
        total++; if ({rd_type, rd_inum} !== {3'd3, 32'd2}) begin bad++; $display("FAIL nop_type_inum got=%0d/%0d exp=3/2", rd_type, rd_inum); end
        total++; if ({rd_value, rd_addr, rd_reg} !== '0) begin bad++; $display("FAIL nop_fields got=%0h/%0h/%0h exp=0", rd_value, rd_addr, rd_reg); end
        total++; if (level !== 5'd1) begin bad++; $display("FAIL nop_level got=%0d exp=1", level); end
        capture_en = 1'b0;
        tick();
        total++; if ({rd_valid, level} !== {1'b0, 5'd0}) begin bad++; $display("FAIL seq_drained got=%0h/%0d exp=0/0", rd_valid, level); end
    endtask

    task automatic test_overflow_and_full_push_pop();
        logic [31:0] exp_inum;
        do_reset();
        capture_en = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        total++; if (level !== 5'd16) begin bad++; $display("FAIL ovf_level got=%0d exp=16", level); end
        total++; if (drop_count !== 32'd4) begin bad++; $display("FAIL ovf_drop got=%0d exp=4", drop_count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0h exp=1", overflow); end
        total++; if (inst_count !== 32'd20) begin bad++; $display("FAIL ovf_icount got=%0d exp=20", inst_count); end
        total++; if (rd_inum !== 32'd0) begin bad++; $display("FAIL ovf_head got=%0d exp=0", rd_inum); end
        rd_ready = 1'b1;
        tick();
        total++; if (level !== 5'd16) begin bad++; $display("FAIL fullpp_level got=%0d exp=16", level); end
        total++; if (drop_count !== 32'd4) begin bad++; $display("FAIL fullpp_drop got=%0d exp=4", drop_count); end
        total++; if (rd_inum !== 32'd1) begin bad++; $display("FAIL fullpp_head got=%0d exp=1", rd_inum); end
        capture_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_inum = (i < 15) ? 32'(i + 1) : 32'd20;
            total++; if (rd_inum !== exp_inum) begin bad++; $display("FAIL drain_inum[%0d] got=%0d exp=%0d", i, rd_inum, exp_inum); end
            tick();
        end
        total++; if (level !== 5'd0) begin bad++; $display("FAIL drain_level got=%0d exp=0", level); end
    endtask

    task automatic test_halt();
        do_reset();
        capture_en = 1'b1; halt = 1'b1; reg_write = 1'b1; wr_reg = 4'd2; wr_data = 16'h0055; mem_addr = 16'h0033; pc = 16'h0010;
        tick();
        halt = 1'b0;
        total++; if ({rd_type, rd_value, rd_addr, rd_pc} !== {3'd4, 16'h0, 16'h0, 16'h0010}) begin bad++; $display("FAIL halt_record got=%0d/%0h/%0h/%0h exp=4/0/0/10", rd_type, rd_value, rd_addr, rd_pc); end
        total++; if ({halted, level} !== {1'b1, 5'd1}) begin bad++; $display("FAIL halt_flag_level got=%0h/%0d exp=1/1", halted, level); end
        for (int i = 0; i < 3; i++) tick();
        total++; if ({cycle_count, inst_count} !== {32'd1, 32'd1}) begin bad++; $display("FAIL halt_frozen got=%0d/%0d exp=1/1", cycle_count, inst_count); end
        total++; if (level !== 5'd1) begin bad++; $display("FAIL halt_single got=%0d exp=1", level); end
        capture_en = 1'b0; reg_write = 1'b0; rd_ready = 1'b1;
        tick();
        total++; if (level !== 5'd0) begin bad++; $display("FAIL halt_drain got=%0d exp=0", level); end
    endtask

    task automatic test_halt_refused();
        do_reset();
        capture_en = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        total++; if ({halted, overflow, drop_count} !== {1'b1, 1'b1, 32'd1}) begin bad++; $display("FAIL halt_ref_status got=%b/%0d exp=11/1", {halted, overflow}, drop_count); end
        total++; if (inst_count !== 32'd17) begin bad++; $display("FAIL halt_ref_icount got=%0d exp=17", inst_count); end
        tick();
        total++; if ({inst_count, drop_count} !== {32'd17, 32'd1}) begin bad++; $display("FAIL halt_ref_frozen got=%0d/%0d exp=17/1", inst_count, drop_count); end
        clear_inputs();
    endtask

    task automatic test_timeout();
        clear_inputs();
        rst_t = 1'b0; capture_en_t = 1'b1; rd_ready_t = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        total++; if ({timeout_t, cycle_count_t} !== {1'b0, 32'd4}) begin bad++; $display("FAIL to_before got=%0h/%0d exp=0/4", timeout_t, cycle_count_t); end
        tick();
        total++; if ({timeout_t, cycle_count_t, level_t} !== {1'b1, 32'd5, 5'd5}) begin bad++; $display("FAIL to_edge got=%0h/%0d/%0d exp=1/5/5", timeout_t, cycle_count_t, level_t); end
        tick(); tick();
        total++; if ({cycle_count_t, inst_count_t, level_t} !== {32'd5, 32'd5, 5'd5}) begin bad++; $display("FAIL to_frozen got=%0d/%0d/%0d exp=5/5/5", cycle_count_t, inst_count_t, level_t); end
        capture_en_t = 1'b0; rd_ready_t = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (rd_inum_t !== 32'(i)) begin bad++; $display("FAIL to_inum[%0d] got=%0d exp=%0d", i, rd_inum_t, i); end
            tick();
        end
        rd_ready_t = 1'b0;
        total++; if ({rd_inum_t, level_t} !== {32'd4, 5'd1}) begin bad++; $display("FAIL to_last got=%0d/%0d exp=4/1", rd_inum_t, level_t); end
        rst_t = 1'b1;
        tick();
        rst_t = 1'b0;
        total++; if ({rd_valid_t, level_t, timeout_t, halted_t, overflow_t} !== 9'd0) begin bad++; $display("FAIL to_rst_status got=%0h/%0d/%0h exp=0/0/0", rd_valid_t, level_t, timeout_t); end
        total++; if ({cycle_count_t, inst_count_t, drop_count_t, rd_inum_t} !== 128'd0) begin bad++; $display("FAIL to_rst_counters got=%0d/%0d/%0d exp=0", cycle_count_t, inst_count_t, drop_count_t); end
        capture_en_t = 1'b1;
        tick();
        capture_en_t = 1'b0;
        total++; if ({level_t, cycle_count_t} !== {5'd1, 32'd1}) begin bad++; $display("FAIL to_rerun got=%0d/%0d exp=1/1", level_t, cycle_count_t); end
    endtask

    initial begin
        test_reset();
        test_reg_write();
        test_load_store_nop();
        test_overflow_and_full_push_pop();
        test_halt();
        test_halt_refused();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Synthesizable commit-trace capture unit for the single-cycle `cpu`. Each enabled cycle it classifies the retiring instruction (register write, load, store, branch/NOP, halt) and tags it with a sequential instruction number. It pushes a trace record into a parametrised FIFO that a host or debug port drains through a valid/ready handshake. It also keeps cycle and instruction counters, a cycle-limit watchdog, and drop/overflow status, so traces can be collected on hardware and in long simulations without `$fdisplay`.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `DATA_W`, 16: width of PC, instruction, register/memory data and address.
- `CNT_W`, 32: width of the cycle, instruction and drop counters.
- `CYCLE_LIMIT`, 100000: watchdog threshold in enabled cycles.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `capture_en`  in  1  high when the CPU is out of reset and retiring; low cycles are ignored.
- `pc`, `inst`  in  DATA_W each  PC and instruction of the retiring instruction.
- `reg_write`, `mem_read`, `mem_write`, `halt`  in  1 each  commit controls.
- `wr_reg`  in  4  destination register.
- `wr_data`  in  DATA_W  register write data.
- `mem_addr`, `mem_data`  in  DATA_W each  memory address and store data.
- `rd_valid`  out  1  FIFO head is valid.
- `rd_ready`  in  1  consumer accepts the head.
- `rd_type`  out  3  record type: 0 REG, 1 LOAD, 2 STORE, 3 NOP, 4 HALT.
- `rd_inum`  out  CNT_W  instruction number.
- `rd_pc`, `rd_value`, `rd_addr`  out  DATA_W each  record fields.
- `rd_reg`  out  4  destination register.
- `cycle_count`, `inst_count`, `drop_count`  out  CNT_W each  counters.
- `halted`, `timeout`, `overflow`  out  1 each  sticky status.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- States: RUN and STOPPED.
  - Reset enters RUN.
  - RUN goes to STOPPED on a captured HALT or when `timeout` sets.
  - STOPPED is left only by `rst`. In STOPPED no captures or counter updates occur; draining continues.
- Classification in an enabled RUN cycle. The first matching rule wins:
  - `halt` gives HALT with `value=0` and `addr=0`.
  - `reg_write & mem_read` gives LOAD with `value=wr_data`, `addr=mem_addr`, `reg=wr_reg`.
  - `reg_write` gives REG with `value=wr_data`, `reg=wr_reg`, `addr=0`.
  - `mem_write` gives STORE with `value=mem_data`, `addr=mem_addr`, `reg=0`.
  - Otherwise NOP, with all payload fields 0.
- Every captured record gets `inum = inst_count` (the pre-increment value). `inst_count` then increments by 1. Each class counts as one instruction.
- `cycle_count` increments on every enabled RUN cycle.
- `timeout` sets on the cycle in which `cycle_count` would reach `CYCLE_LIMIT`. That cycle's record is still captured.
- FIFO is first-word-fall-through:
  - Pop occurs when `rd_valid & rd_ready`.
  - Push is refused when the FIFO is full and no pop happens that cycle.
  - Simultaneous push and pop on a full FIFO succeeds, and `level` is unchanged.
  - Simultaneous push and pop on an empty FIFO: the record enters the FIFO, and nothing pops because `rd_valid` was low.
- Refused push: the record is lost, `drop_count` increments, `overflow` sets (sticky), and `inst_count` still increments so inum gaps reveal the drop. A refused HALT still sets `halted` and stops capture.
- Read and write pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. Full and empty are derived from `level`.
- Counters saturate at all-ones and do not wrap.

## Timing
- Capture latency: inputs sampled on edge N appear on `rd_*` with `rd_valid=1` after edge N when the FIFO was empty. `level` updates on the same edge.
- `rd_*` fields are stable while `rd_valid & ~rd_ready`.
- Reset values: `rd_valid=0`, `level=0`, all counters 0, `halted=timeout=overflow=0`, `rd_*` fields 0, pointers 0.
- `rst` asserted mid-operation flushes the FIFO on that edge. Inputs in a reset cycle are not captured.
- `halted` and `timeout` rise on the same edge the corresponding record is pushed.

## Test plan
- Reset, then one enabled cycle with `reg_write=1`, `wr_reg=3`, `wr_data=0x00A5`, `pc=0x0002`. Expect the next cycle to show `rd_valid=1`, type 0, inum 0, reg 3, value 0x00A5, pc 0x0002, `level=1`, `inst_count=1`.
- Sequence LOAD (addr 0x0010, data 0x1234), STORE (addr 0x0020, data 0xBEEF), NOP, with `rd_ready=1`. Expect types 1, 2, 3 with inums 0, 1, 2 in order, and `level` never above 1.
- `rd_ready=0` with 20 NOPs at DEPTH=16. Expect `level=16`, `drop_count=4`, `overflow=1`, `inst_count=20`. Draining then yields inums 0–15.
- Full FIFO with `rd_ready=1` and a new push in the same cycle. Expect `level` to stay 16, `drop_count` unchanged, and head inum to advance by 1.
- `halt` asserted together with `reg_write=1`. Expect a single type-4 record and `halted=1`. Further enabled cycles must leave `cycle_count` and `inst_count` frozen.
- CYCLE_LIMIT=5 and 7 enabled NOPs. Expect `timeout=1` with `cycle_count=5`, exactly 5 records (inum 0–4), and `rst` clearing everything to the reset values.
